// File: rtl/op_buffer_fifo.sv
// op_buffer_fifo: per-group operand FIFOs (mask + OPS_PER_GRP vector operands) with ready/valid,
// optional empty-FIFO bypass, occupancy reporting and synchronous flush.
module op_buffer_fifo #(
    parameter int NGROUPS     = 2,
    parameter int OPS_PER_GRP = 2,
    parameter int VREG_W      = 512,
    parameter int MASK_W      = 16,
    parameter int DEPTH       = 4,
    parameter int BYPASS      = 1
) (
    input  logic                                    CLK,
    input  logic                                    nRST,
    input  logic                                    flush,
    input  logic [NGROUPS*OPS_PER_GRP-1:0]          in_dvalid,
    input  logic [NGROUPS-1:0]                      in_mvalid,
    input  logic [NGROUPS*OPS_PER_GRP*VREG_W-1:0]   in_vreg,
    input  logic [NGROUPS*MASK_W-1:0]               in_vmask,
    output logic [NGROUPS-1:0]                      in_full,
    input  logic [NGROUPS-1:0]                      out_ready,
    output logic [NGROUPS-1:0]                      out_ivalid,
    output logic [NGROUPS*OPS_PER_GRP*VREG_W-1:0]   out_vreg,
    output logic [NGROUPS*MASK_W-1:0]               out_vmask,
    output logic [NGROUPS*$clog2(DEPTH+1)-1:0]      occ
);
    localparam int OW = OPS_PER_GRP * VREG_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    genvar g;
    for (g = 0; g < NGROUPS; g++) begin : g_grp
        logic [OW-1:0]     r_data [DEPTH];
        logic [MASK_W-1:0] r_mask [DEPTH];
        logic [PW-1:0]     r_wp, r_rp;
        logic [CW-1:0]     r_cnt;
        logic w_gvalid, w_full, w_empty, w_byp, w_valid, w_pop, w_take, w_push;

        assign w_gvalid = (&in_dvalid[g*OPS_PER_GRP +: OPS_PER_GRP]) & in_mvalid[g];
        assign w_full   = r_cnt == CW'(DEPTH);
        assign w_empty  = r_cnt == '0;
        assign w_byp    = (BYPASS != 0) && w_empty;
        // flush gates the output, which also blocks any bypass in that cycle
        assign w_valid  = !flush && (!w_empty || (w_byp && w_gvalid));
        assign w_pop    = w_valid && out_ready[g] && !w_empty;
        assign w_take   = w_valid && w_byp && out_ready[g];
        assign w_push   = w_gvalid && !w_full && !w_take && !flush;

        assign in_full[g]                    = w_full;
        assign out_ivalid[g]                 = w_valid;
        assign out_vreg[g*OW +: OW]          = w_byp ? in_vreg[g*OW +: OW] : r_data[r_rp];
        assign out_vmask[g*MASK_W +: MASK_W] = w_byp ? in_vmask[g*MASK_W +: MASK_W] : r_mask[r_rp];
        assign occ[g*CW +: CW]               = r_cnt;

        always_ff @(posedge CLK) begin
            if (!nRST) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_data[i] <= '0;
                    r_mask[i] <= '0;
                end
            end else if (flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_data[r_wp] <= in_vreg[g*OW +: OW];
                    r_mask[r_wp] <= in_vmask[g*MASK_W +: MASK_W];
                    r_wp         <= r_wp + 1'b1;
                end
                if (w_pop) r_rp <= r_rp + 1'b1;
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule
